// File: rtl/lamp_conflict_monitor_pkg.sv
// Shared definitions for the lamp conflict monitor: light codes, head indices,
// mode encoding and the conflict rule helpers.
package lamp_conflict_monitor_pkg;

  localparam int NUM_HEADS = 14;
  localparam int NUM_VEH   = 4;
  localparam int CODE_W    = 3;
  localparam int LIGHT_W   = NUM_HEADS * CODE_W;

  localparam logic [2:0] CODE_RED   = 3'b100;
  localparam logic [2:0] CODE_AMBER = 3'b010;
  localparam logic [2:0] CODE_GREEN = 3'b001;
  localparam logic [2:0] CODE_OFF   = 3'b000;

  localparam int HEAD_F1  = 0;
  localparam int HEAD_F2  = 1;
  localparam int HEAD_F6  = 2;
  localparam int HEAD_F9  = 3;
  localparam int HEAD_P1  = 4;
  localparam int HEAD_P2  = 5;
  localparam int HEAD_P3  = 6;
  localparam int HEAD_P4  = 7;
  localparam int HEAD_P5  = 8;
  localparam int HEAD_P6  = 9;
  localparam int HEAD_P7  = 10;
  localparam int HEAD_P8  = 11;
  localparam int HEAD_P9  = 12;
  localparam int HEAD_P10 = 13;

  typedef enum logic [1:0] {
    MODE_STARTUP     = 2'b00,
    MODE_PASS        = 2'b01,
    MODE_NIGHT       = 2'b10,
    MODE_FLASH_FAULT = 2'b11
  } mode_e;

  function automatic logic [2:0] head_code(input logic [LIGHT_W-1:0] v, input int idx);
    logic [5:0] base;
    base = 6'(idx * CODE_W);
    return v[base +: CODE_W];
  endfunction

  function automatic logic [LIGHT_W-1:0] all_red();
    return {NUM_HEADS{CODE_RED}};
  endfunction

  // Vehicle heads amber or dark depending on phase; pedestrian heads dark.
  function automatic logic [LIGHT_W-1:0] flash_pattern(input logic phase_on);
    logic [LIGHT_W-1:0] v;
    v = {LIGHT_W{1'b0}};
    for (int h = 0; h < NUM_VEH; h++) begin
      v[6'(h * CODE_W) +: CODE_W] = phase_on ? CODE_AMBER : CODE_OFF;
    end
    return v;
  endfunction

  function automatic logic conflict_bad(input logic [LIGHT_W-1:0] v);
    logic illegal;
    logic grp_a;
    logic grp_b;
    logic veh_active;
    logic ped_walk;
    logic [2:0] code;
    illegal    = 1'b0;
    veh_active = 1'b0;
    for (int h = 0; h < NUM_HEADS; h++) begin
      code    = head_code(v, h);
      illegal = illegal | ~((code == CODE_RED) | (code == CODE_AMBER) | (code == CODE_GREEN));
    end
    for (int h = 0; h < NUM_VEH; h++) begin
      veh_active = veh_active | (head_code(v, h) != CODE_RED);
    end
    grp_a    = (head_code(v, HEAD_F1) != CODE_RED) | (head_code(v, HEAD_F6) != CODE_RED);
    grp_b    = (head_code(v, HEAD_F2) != CODE_RED) | (head_code(v, HEAD_F9) != CODE_RED);
    ped_walk = (head_code(v, HEAD_P5) == CODE_GREEN) | (head_code(v, HEAD_P10) == CODE_GREEN);
    return illegal | (grp_a & grp_b) | (ped_walk & veh_active);
  endfunction

endpackage

// File: rtl/lamp_conflict_monitor_blink_gen.sv
// Amber flash timebase. phase_on is the phase that takes effect at the coming
// clock edge, so lamp registers can load it on the same edge as a mode change.
module lamp_conflict_monitor_blink_gen #(
  parameter int BLINK_HALF = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic run,
  output logic phase_on
);

  localparam int CW = ($clog2(BLINK_HALF) > 0) ? $clog2(BLINK_HALF) : 1;

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_next_s;
  logic          phase_r;
  logic          phase_next_s;

  // Next count and phase: restart forces the "on" phase from count zero.
  always_comb begin
    cnt_next_s   = cnt_r;
    phase_next_s = phase_r;
    if (restart) begin
      cnt_next_s   = {CW{1'b0}};
      phase_next_s = 1'b1;
    end else if (run) begin
      if (cnt_r == CW'(BLINK_HALF - 1)) begin
        cnt_next_s   = {CW{1'b0}};
        phase_next_s = ~phase_r;
      end else begin
        cnt_next_s   = cnt_r + CW'(1);
        phase_next_s = phase_r;
      end
    end else begin
      cnt_next_s   = cnt_r;
      phase_next_s = phase_r;
    end
  end

  // Counter and phase registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= {CW{1'b0}};
      phase_r <= 1'b1;
    end else begin
      cnt_r   <= cnt_next_s;
      phase_r <= phase_next_s;
    end
  end

  assign phase_on = phase_next_s;

endmodule

// File: rtl/lamp_conflict_monitor.sv
// Safety stage between the traffic light controller and the lamp drivers:
// registers lamp codes, detects conflicts and latches a flashing-amber fail-safe.
module lamp_conflict_monitor
  import lamp_conflict_monitor_pkg::*;
#(
  parameter int STARTUP_CYCLES  = 4,
  parameter int BLINK_HALF      = 8,
  parameter int CONFLICT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [41:0] light_in,
  input  logic        night_mode,
  input  logic        clear_fault,
  output logic [41:0] lamp_out,
  output logic        fault,
  output logic [1:0]  mode
);

  localparam int SCW = ($clog2(STARTUP_CYCLES) > 0) ? $clog2(STARTUP_CYCLES) : 1;
  localparam int CCW = $clog2(CONFLICT_CYCLES + 1);

  mode_e          state_r;
  mode_e          state_next_s;
  logic [SCW-1:0] startup_cnt_r;
  logic [SCW-1:0] startup_cnt_next_s;
  logic [CCW-1:0] conflict_cnt_r;
  logic [CCW-1:0] conflict_cnt_next_s;
  logic [41:0]    lamp_r;
  logic [41:0]    lamp_next_s;
  logic           fault_r;
  logic           bad_s;
  logic           fault_hit_s;
  logic           state_change_s;
  logic           flash_next_s;
  logic           blink_restart_s;
  logic           phase_on_s;

  // Monitor is live only while the controller drives the lamps or in night flash.
  always_comb begin
    bad_s       = 1'b0;
    fault_hit_s = 1'b0;
    if ((state_r == MODE_PASS) || (state_r == MODE_NIGHT)) begin
      bad_s       = conflict_bad(light_in);
      fault_hit_s = bad_s && (conflict_cnt_r >= CCW'(CONFLICT_CYCLES - 1));
    end else begin
      bad_s       = 1'b0;
      fault_hit_s = 1'b0;
    end
  end

  // Next-state logic; fault takes priority over night_mode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      MODE_STARTUP: begin
        if (startup_cnt_r == SCW'(STARTUP_CYCLES - 1)) begin
          state_next_s = night_mode ? MODE_NIGHT : MODE_PASS;
        end else begin
          state_next_s = MODE_STARTUP;
        end
      end
      MODE_PASS: begin
        if (fault_hit_s) begin
          state_next_s = MODE_FLASH_FAULT;
        end else if (night_mode) begin
          state_next_s = MODE_NIGHT;
        end else begin
          state_next_s = MODE_PASS;
        end
      end
      MODE_NIGHT: begin
        if (fault_hit_s) begin
          state_next_s = MODE_FLASH_FAULT;
        end else if (!night_mode) begin
          state_next_s = MODE_STARTUP;
        end else begin
          state_next_s = MODE_NIGHT;
        end
      end
      MODE_FLASH_FAULT: begin
        if (clear_fault) begin
          state_next_s = MODE_STARTUP;
        end else begin
          state_next_s = MODE_FLASH_FAULT;
        end
      end
      default: state_next_s = MODE_STARTUP;
    endcase
  end

  // Startup and conflict counters both restart on any state change.
  always_comb begin
    state_change_s      = (state_next_s != state_r);
    startup_cnt_next_s  = {SCW{1'b0}};
    conflict_cnt_next_s = {CCW{1'b0}};
    if (!state_change_s && (state_r == MODE_STARTUP)) begin
      startup_cnt_next_s = startup_cnt_r + SCW'(1);
    end else begin
      startup_cnt_next_s = {SCW{1'b0}};
    end
    if (state_change_s || !bad_s) begin
      conflict_cnt_next_s = {CCW{1'b0}};
    end else if (conflict_cnt_r == CCW'(CONFLICT_CYCLES)) begin
      conflict_cnt_next_s = conflict_cnt_r;
    end else begin
      conflict_cnt_next_s = conflict_cnt_r + CCW'(1);
    end
  end

  // Lamp image follows the next state so mode and lamps change on one edge.
  always_comb begin
    flash_next_s    = (state_next_s == MODE_NIGHT) || (state_next_s == MODE_FLASH_FAULT);
    blink_restart_s = flash_next_s && (state_next_s != state_r);
    lamp_next_s     = all_red();
    case (state_next_s)
      MODE_STARTUP:     lamp_next_s = all_red();
      MODE_PASS:        lamp_next_s = light_in;
      MODE_NIGHT:       lamp_next_s = flash_pattern(phase_on_s);
      MODE_FLASH_FAULT: lamp_next_s = flash_pattern(phase_on_s);
      default:          lamp_next_s = all_red();
    endcase
  end

  lamp_conflict_monitor_blink_gen #(
    .BLINK_HALF (BLINK_HALF)
  ) u_blink_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart  (blink_restart_s),
    .run      (flash_next_s),
    .phase_on (phase_on_s)
  );

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= MODE_STARTUP;
      startup_cnt_r  <= {SCW{1'b0}};
      conflict_cnt_r <= {CCW{1'b0}};
      lamp_r         <= all_red();
      fault_r        <= 1'b0;
    end else begin
      state_r        <= state_next_s;
      startup_cnt_r  <= startup_cnt_next_s;
      conflict_cnt_r <= conflict_cnt_next_s;
      lamp_r         <= lamp_next_s;
      fault_r        <= (state_next_s == MODE_FLASH_FAULT);
    end
  end

  assign lamp_out = lamp_r;
  assign fault    = fault_r;
  assign mode     = state_r;

endmodule

// File: tb/tb_lamp_conflict_monitor.sv
// Directed and randomized bench for lamp_conflict_monitor against a
// cycle-count based reference model.
module tb_lamp_conflict_monitor;

  localparam int SC = 4;
  localparam int BH = 8;
  localparam int CC = 2;

  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] AMBER = 3'b010;
  localparam logic [2:0] GREEN = 3'b001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [41:0] light_in;
  logic        night_mode;
  logic        clear_fault;
  logic [41:0] lamp_out;
  logic        fault;
  logic [1:0]  mode;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model: mode number, cycles spent in current mode, current run of bad cycles.
  int          m_mode;
  int          m_elapsed;
  int          m_run;
  logic [41:0] m_lamp;

  lamp_conflict_monitor #(
    .STARTUP_CYCLES  (SC),
    .BLINK_HALF      (BH),
    .CONFLICT_CYCLES (CC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .light_in    (light_in),
    .night_mode  (night_mode),
    .clear_fault (clear_fault),
    .lamp_out    (lamp_out),
    .fault       (fault),
    .mode        (mode)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [41:0] obs, input logic [41:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [2:0] hc(input logic [41:0] v, input int i);
    logic [5:0] b;
    b = 6'(i * 3);
    return v[b +: 3];
  endfunction

  function automatic logic [41:0] with_head(input logic [41:0] v, input int i, input logic [2:0] c);
    logic [41:0] r;
    logic [5:0]  b;
    r = v;
    b = 6'(i * 3);
    r[b +: 3] = c;
    return r;
  endfunction

  function automatic logic [41:0] red_all();
    logic [41:0] r;
    r = 42'd0;
    for (int i = 0; i < 14; i++) r = with_head(r, i, RED);
    return r;
  endfunction

  function automatic logic is_bad(input logic [41:0] v);
    logic [2:0] c;
    int nveh;
    for (int i = 0; i < 14; i++) begin
      c = hc(v, i);
      if (c != RED && c != AMBER && c != GREEN) return 1'b1;
    end
    if ((hc(v, 0) != RED || hc(v, 2) != RED) && (hc(v, 1) != RED || hc(v, 3) != RED)) return 1'b1;
    nveh = 0;
    for (int i = 0; i < 4; i++) if (hc(v, i) != RED) nveh++;
    if ((hc(v, 8) == GREEN || hc(v, 13) == GREEN) && nveh > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_mode    = 0;
    m_elapsed = 0;
    m_run     = 0;
    m_lamp    = red_all();
  endtask

  task automatic model_step();
    logic bad;
    int   nm;
    bad = (m_mode == 1 || m_mode == 2) && is_bad(light_in);
    nm  = m_mode;
    case (m_mode)
      0: if (m_elapsed + 1 == SC) nm = night_mode ? 2 : 1;
      1: if (bad && m_run + 1 >= CC) nm = 3; else if (night_mode) nm = 2;
      2: if (bad && m_run + 1 >= CC) nm = 3; else if (!night_mode) nm = 0;
      default: if (clear_fault) nm = 0;
    endcase
    if (nm != m_mode) begin
      m_elapsed = 0;
      m_run     = 0;
    end else begin
      m_elapsed++;
      m_run = bad ? m_run + 1 : 0;
    end
    m_mode = nm;
    if (m_mode == 0) m_lamp = red_all();
    else if (m_mode == 1) m_lamp = light_in;
    else begin
      m_lamp = 42'd0;
      for (int i = 0; i < 4; i++)
        m_lamp = with_head(m_lamp, i, ((m_elapsed / BH) % 2 == 0) ? AMBER : 3'b000);
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_val({tag, "_lamp"}, lamp_out, m_lamp);
    check_val({tag, "_mode"}, {40'd0, mode}, 42'(m_mode));
    check_val({tag, "_fault"}, {41'd0, fault}, (m_mode == 3) ? 42'd1 : 42'd0);
  endtask

  function automatic logic [41:0] rand_light();
    logic [41:0] v;
    int r;
    v = 42'd0;
    for (int i = 0; i < 14; i++) begin
      r = int'($urandom_range(0, 19));
      if (r < 12) v = with_head(v, i, RED);
      else if (r < 15) v = with_head(v, i, AMBER);
      else if (r < 18) v = with_head(v, i, GREEN);
      else if (r < 19) v = with_head(v, i, 3'b000);
      else v = with_head(v, i, 3'($urandom_range(0, 7)));
    end
    return v;
  endfunction

  logic [41:0] pat_a;
  logic [41:0] conf_f1f2;
  logic [41:0] conf_f6f9;
  logic [41:0] p5_bad;

  initial begin
    pat_a     = with_head(with_head(red_all(), 0, GREEN), 2, GREEN);
    conf_f1f2 = with_head(with_head(red_all(), 0, GREEN), 1, GREEN);
    conf_f6f9 = with_head(with_head(red_all(), 2, GREEN), 3, GREEN);
    p5_bad    = with_head(red_all(), 8, 3'b011);

    rst_n       = 1'b1;
    light_in    = red_all();
    night_mode  = 1'b0;
    clear_fault = 1'b0;
    #1 rst_n = 1'b0;
    model_reset();
    #11;
    check_val("rst_lamp", lamp_out, 42'h24924924924);
    check_val("rst_mode", {40'd0, mode}, 42'd0);
    check_val("rst_fault", {41'd0, fault}, 42'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    light_in = pat_a;
    repeat (6) cycle("startup");

    light_in = conf_f1f2; cycle("short_conf");
    light_in = pat_a; repeat (3) cycle("short_conf_after");

    light_in = conf_f1f2; repeat (2) cycle("conf2");
    check_val("conf2_latched", {41'd0, fault}, 42'd1);
    light_in = pat_a; repeat (2 * BH + 2) cycle("flash");

    clear_fault = 1'b1; cycle("clear");
    clear_fault = 1'b0; repeat (6) cycle("after_clear");
    clear_fault = 1'b1; cycle("clear_in_pass");
    clear_fault = 1'b0; cycle("clear_in_pass2");
    check_val("clear_ignored", {40'd0, mode}, 42'd1);

    light_in = p5_bad; repeat (3) cycle("p5_illegal");
    check_val("p5_latched", {40'd0, mode}, 42'd3);
    light_in = pat_a; clear_fault = 1'b1; cycle("clear2");
    clear_fault = 1'b0; repeat (5) cycle("restart2");

    night_mode = 1'b1; repeat (20) cycle("night");
    light_in = conf_f6f9; repeat (2) cycle("night_conf");
    check_val("night_fault", {40'd0, mode}, 42'd3);
    light_in = pat_a; repeat (3) cycle("fault_night_held");
    clear_fault = 1'b1; cycle("clear3");
    clear_fault = 1'b0; repeat (7) cycle("startup_to_night");
    night_mode = 1'b0; repeat (7) cycle("night_exit");

    light_in = conf_f1f2; repeat (2) cycle("conf4");
    light_in = pat_a; repeat (3) cycle("flash4");
    #3 rst_n = 1'b0;
    #1;
    check_val("async_lamp", lamp_out, 42'h24924924924);
    check_val("async_mode", {40'd0, mode}, 42'd0);
    check_val("async_fault", {41'd0, fault}, 42'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) cycle("post_async");

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 59) == 0) night_mode = ~night_mode;
      clear_fault = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 9) < 3) light_in = rand_light();
      else if ($urandom_range(0, 9) < 2) light_in = pat_a;
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
